// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared types and constants for the UART receive path.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GUARD  = 3'd5,
    BREAK  = 3'd6
  } rx_state_t;

  localparam int SYNC_STAGES = 2;

  // Bit-period counter must hold CLKS_PER_BIT itself.
  function automatic int cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// +----------------------------------------------------------------------+
// | uart_rx_sync                                                         |
// | Multi-flop synchroniser for an idle-high asynchronous serial line.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  // Reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// +----------------------------------------------------------------------+
// | uart_rx_core                                                         |
// | Mid-bit sampling UART receiver with a ready/valid holding register.  |
// | Optional parity checking is built when UART_RX_PARITY_EN is defined. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int MSB_FIRST    = 1,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_data_line,
  input  logic                 i_data_ack,
  output logic [DATA_BITS-1:0] o_data_byte_out,
  output logic                 o_data_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $error("uart_rx_core: unsupported parameter set");
  end

  rx_state_t            state;
  rx_state_t            state_next;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_val;
  logic                 cnt_load;
  logic                 expire;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_pos;
  logic [DATA_BITS-1:0] shreg;
  logic                 sample_data;
  logic                 complete;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (i_clk),
    .rst      (i_rst),
    .async_in (i_rx_data_line),
    .sync_out (rx_s)
  );

  assign expire  = (cnt == CNT_W'(1));
  assign bit_pos = (MSB_FIRST != 0) ? (LAST_IDX - bit_idx) : bit_idx;
  assign o_busy  = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic sample_par;
  logic par_err;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_load    = 1'b0;
    cnt_val     = BIT_CNT;
    sample_data = 1'b0;
    complete    = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_load   = 1'b1;
          cnt_val    = HALF_CNT;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s) begin
            state_next = DATA;
            cnt_load   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          sample_data = 1'b1;
          cnt_load    = 1'b1;
          if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (expire) begin
          sample_par = 1'b1;
          cnt_load   = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (expire) begin
          complete = 1'b1;
          if (!rx_s) begin
            state_next = BREAK;
          end else if (STOP_BITS == 2) begin
            state_next = GUARD;
            cnt_load   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GUARD: begin
        if (expire) begin
          state_next = IDLE;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_load) begin
        cnt <= cnt_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == START) begin
        bit_idx <= '0;
      end else if (sample_data) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (sample_data) begin
        shreg[bit_pos] <= rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par_err <= 1'b0;
    end else if (sample_par) begin
      par_err <= rx_s ^ (^shreg) ^ 1'(PARITY_ODD);
    end
  end
`endif

  // A completing frame wins over a plain ack; ack in the same cycle frees the slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data_byte_out <= '0;
      o_data_ready    <= 1'b0;
      o_frame_err     <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (complete) begin
        if (!o_data_ready || i_data_ack) begin
          o_data_byte_out <= shreg;
          o_data_ready    <= 1'b1;
          o_frame_err     <= !rx_s;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (i_data_ack && o_data_ready) begin
        o_data_ready <= 1'b0;
        o_frame_err  <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_parity_err <= 1'b0;
    end else if (complete) begin
      if (!o_data_ready || i_data_ack) begin
        o_parity_err <= par_err;
      end
    end else if (i_data_ack && o_data_ready) begin
      o_parity_err <= 1'b0;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// +----------------------------------------------------------------------+
// | tb_uart_rx_core                                                      |
// | Cycle-map driven stimulus with a frame-level reference model.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
  localparam int DB  = 7;
  localparam int MSB = 0;
  localparam int P   = 1;
`else
  localparam int DB  = 8;
  localparam int MSB = 1;
  localparam int P   = 0;
`endif
  localparam int CPB   = 10;
  localparam int HALF  = CPB / 2;
  localparam int STOPB = 1;
  localparam int ODD   = 0;
  localparam int SLOT  = (DB + P + 2) * CPB;
  localparam int MAXC  = 16000;
  localparam logic [31:0] MASK = (32'd1 << DB) - 32'd1;

  localparam int SG_DATA = 0, SG_RDY = 1, SG_FE = 2, SG_PE = 3, SG_OVR = 4, SG_BUSY = 5;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          fe;
    bit          pe;
  } ev_t;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } pin_t;

  logic          clk;
  logic          rst;
  logic          rx;
  logic          ack;
  logic [DB-1:0] data_out;
  logic          ready;
  logic          ferr;
  logic          perr;
  logic          ovr;
  logic          busy;

  int  cyc;
  int  t;
  int  end_cyc;
  int  checks;
  int  errors;
  bit  low_map  [MAXC];
  bit  ack_map  [MAXC];
  bit  rst_map  [MAXC];
  bit  busy_map [MAXC];
  ev_t  evq[$];
  pin_t pins[$];

  uart_rx_core #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .MSB_FIRST    (MSB),
    .STOP_BITS    (STOPB),
    .PARITY_ODD   (ODD)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rx_data_line  (rx),
    .i_data_ack      (ack),
    .o_data_byte_out (data_out),
    .o_data_ready    (ready),
    .o_frame_err     (ferr),
    .o_parity_err    (perr),
    .o_overrun       (ovr),
    .o_busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Schedules one frame with its start edge at pin cycle t; returns the stop-sample cycle.
  function automatic int send(input logic [31:0] w_in, input bit bad_par, input bit bad_stop);
    logic [31:0] w;
    int          e;
    int          s;
    int          b;
    int          h;
    bit          pb;
    w = w_in & MASK;
    e = t;
    s = e + 2 + HALF + (DB + P + 1) * CPB;
    for (int c = e; c < e + CPB; c++) low_map[c] = 1'b1;
    for (int k = 0; k < DB; k++) begin
      b = (MSB != 0) ? DB - 1 - k : k;
      if (!w[b]) for (int c = e + (k + 1) * CPB; c < e + (k + 2) * CPB; c++) low_map[c] = 1'b1;
    end
    if (P != 0) begin
      pb = (^w) ^ (ODD != 0) ^ bad_par;
      if (!pb) for (int c = e + (DB + 1) * CPB; c < e + (DB + 2) * CPB; c++) low_map[c] = 1'b1;
    end
    if (bad_stop) begin
      h = e + (DB + P + 4) * CPB;
      for (int c = e + (DB + P + 1) * CPB; c < h; c++) low_map[c] = 1'b1;
      for (int c = e + 3; c <= h + 2; c++) busy_map[c] = 1'b1;
      t = h + CPB;
    end else begin
      for (int c = e + 3; c <= s; c++) busy_map[c] = 1'b1;
      t = e + SLOT;
    end
    evq.push_back('{s + 1, w, bad_stop, bad_par && (P != 0)});
    return s;
  endfunction

  function automatic void glitch(input int len);
    for (int c = t; c < t + len; c++) low_map[c] = 1'b1;
    for (int c = t + 3; c <= t + 2 + HALF; c++) busy_map[c] = 1'b1;
    t = t + len + 20;
  endfunction

  // Starts a frame, then abandons it with a one-cycle reset during data bit 3.
  function automatic int reset_mid();
    int e;
    int r;
    int s;
    e = t;
    s = send(32'hC3, 1'b0, 1'b0);
    r = e + 4 * CPB + 3;
    void'(evq.pop_back());
    for (int c = r; c <= s; c++) low_map[c] = 1'b0;
    for (int c = r + 1; c <= s; c++) busy_map[c] = 1'b0;
    rst_map[r] = 1'b1;
    t = r + 20;
    return r;
  endfunction

  function automatic void pin(input int c, input int sig, input logic [31:0] v, input string nm);
    pins.push_back('{c, sig, v, nm});
  endfunction

  function automatic logic [31:0] pick(input int sig);
    case (sig)
      SG_DATA: return 32'(data_out);
      SG_RDY:  return 32'(ready);
      SG_FE:   return 32'(ferr);
      SG_PE:   return 32'(perr);
      SG_OVR:  return 32'(ovr);
      default: return 32'(busy);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Inputs change 1 ns after each rising edge, taken from the per-cycle maps.
  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rx  = !low_map[cyc];
      ack = ack_map[cyc];
      rst = rst_map[cyc];
    end
  end

  // Reference model of the holding register, advanced once per cycle.
  initial begin
    logic [31:0] e_data;
    bit          e_rdy, e_fe, e_pe, e_ovr;
    bit          p_ack, p_rst;
    ev_t         ev;
    int          c;
    e_data = '0; e_rdy = 0; e_fe = 0; e_pe = 0; p_ack = 0; p_rst = 1;
    forever begin
      @(negedge clk);
      c     = cyc;
      e_ovr = 0;
      if (p_rst) begin
        e_data = '0; e_rdy = 0; e_fe = 0; e_pe = 0;
      end else if (evq.size() > 0 && evq[0].cyc == c) begin
        ev = evq.pop_front();
        if (!e_rdy || p_ack) begin
          e_data = ev.data; e_rdy = 1; e_fe = ev.fe; e_pe = ev.pe;
        end else begin
          e_ovr = 1;
        end
      end else if (p_ack && e_rdy) begin
        e_rdy = 0; e_fe = 0; e_pe = 0;
      end
      if (c >= 2 && c < MAXC) begin
        chk("data", 32'(data_out), e_data);
        chk("ready", 32'(ready), 32'(e_rdy));
        chk("frame_err", 32'(ferr), 32'(e_fe));
        chk("parity_err", 32'(perr), 32'(e_pe));
        chk("overrun", 32'(ovr), 32'(e_ovr));
        chk("busy", 32'(busy), 32'(busy_map[c]));
      end
      foreach (pins[i]) if (pins[i].cyc == c) chk(pins[i].nm, pick(pins[i].sig), pins[i].val);
      p_ack = ack;
      p_rst = rst;
    end
  end

  initial begin
    int s, s1, s2, g, r, rs;
    checks = 0;
    errors = 0;
    for (int c = 0; c < 4; c++) rst_map[c] = 1'b1;
    pin(3, SG_RDY, 32'd0, "reset_ready");
    pin(3, SG_BUSY, 32'd0, "reset_busy");
    t = 20;

    s = send(32'h79, 1'b0, 1'b0);
    pin(s + 1, SG_DATA, 32'h79 & MASK, "word_79");
    pin(s + 1, SG_RDY, 32'd1, "ready_79");
    pin(s + 1, SG_FE, 32'd0, "ferr_79");
    pin(s, SG_RDY, 32'd0, "ready_before_stop");
    ack_map[s + 3] = 1'b1;
    pin(s + 3, SG_RDY, 32'd1, "ready_hold_ack");
    pin(s + 4, SG_RDY, 32'd0, "ready_cleared");
    t = t + 20;

    g = t;
    glitch(3);
    pin(g + 4, SG_BUSY, 32'd1, "glitch_busy");
    pin(g + HALF + 4, SG_BUSY, 32'd0, "glitch_idle");
    pin(g + HALF + 4, SG_RDY, 32'd0, "glitch_no_word");

    s = send(32'hA5, 1'b0, 1'b1);
    pin(s + 1, SG_DATA, 32'hA5 & MASK, "word_a5");
    pin(s + 1, SG_FE, 32'd1, "ferr_a5");
    pin(s + 1 + CPB, SG_BUSY, 32'd1, "break_busy");
    ack_map[t - 5] = 1'b1;
    t = t + 10;

    s1 = send(32'h11, 1'b0, 1'b0);
    s2 = send(32'h22, 1'b0, 1'b0);
    pin(s2, SG_OVR, 32'd0, "ovr_before");
    pin(s2 + 1, SG_OVR, 32'd1, "ovr_pulse");
    pin(s2 + 1, SG_DATA, 32'h11, "ovr_keeps_11");
    pin(s2 + 2, SG_OVR, 32'd0, "ovr_one_cycle");
    ack_map[s2 + 5] = 1'b1;
    t = t + 20;

    s1 = send(32'h11, 1'b0, 1'b0);
    s2 = send(32'h22, 1'b0, 1'b0);
    ack_map[s2] = 1'b1;
    pin(s2 + 1, SG_DATA, 32'h22, "ack_at_stop_22");
    pin(s2 + 1, SG_OVR, 32'd0, "ack_at_stop_no_ovr");
    pin(s2 + 1, SG_RDY, 32'd1, "ack_at_stop_ready");
    ack_map[s2 + 4] = 1'b1;
    t = t + 20;

    s = send(32'h5A, 1'b0, 1'b0);
    pin(s + 1, SG_DATA, 32'h5A & MASK, "word_5a");
    pin(s + 1, SG_PE, 32'd0, "perr_good");
    ack_map[s + 3] = 1'b1;
    s = send(32'h5A, bit'(P), 1'b0);
    pin(s + 1, SG_DATA, 32'h5A & MASK, "word_5a_flip");
    pin(s + 1, SG_PE, 32'(P), "perr_flip");
    t = t + 20;

    r = reset_mid();
    pin(r, SG_RDY, 32'd1, "ready_before_rst");
    pin(r + 1, SG_DATA, 32'd0, "rst_data");
    pin(r + 1, SG_RDY, 32'd0, "rst_ready");
    pin(r + 1, SG_FE, 32'd0, "rst_ferr");
    pin(r + 1, SG_PE, 32'd0, "rst_perr");
    pin(r + 1, SG_OVR, 32'd0, "rst_ovr");
    pin(r + 1, SG_BUSY, 32'd0, "rst_busy");
    s = send(32'h3C, 1'b0, 1'b0);
    pin(s + 1, SG_DATA, 32'h3C & MASK, "word_3c");
    pin(s + 1, SG_RDY, 32'd1, "ready_3c");
    t = t + 20;

    rs = t;
    for (int n = 0; n < 40 && t < MAXC - 600; n++) begin
      if ($urandom_range(0, 3) != 0) t = t + $urandom_range(1, 40);
      s = send($urandom, (P != 0) && ($urandom_range(0, 3) == 0), $urandom_range(0, 9) == 0);
    end
    for (int c = rs; c < t + 50; c++) ack_map[c] = ($urandom_range(0, 5) == 0);
    end_cyc = t + 100;

    wait (cyc >= end_cyc);
    @(posedge clk);
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL pending_frames actual=%0d required=0", evq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver, successor to the fixed 8-bit `UartRxr`. It recovers serial frames from an asynchronous RX pin using mid-bit sampling and presents each word on a ready/valid holding register. It reports framing, parity and overrun errors and sits between the board RX pin and the command/FIFO logic. Word width, bit order, stop-bit count and bit period are set by parameters.

## Interface
- CLKS_PER_BIT, 10, clocks per bit period; ≥4.
- DATA_BITS, 8, data bits per frame; 5..9.
- MSB_FIRST, 1, 1 = first data bit is the MSB (current link convention); 0 = LSB first.
- STOP_BITS, 1, 1 or 2; only the first stop bit is checked.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; used only with `UART_RX_PARITY_EN`.

Ports:
- i_clk  in  1  system clock; the single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_data_line  in  1  asynchronous serial input; idles high.
- i_data_ack  in  1  consumer accepts the word when `o_data_ready` is high.
- o_data_byte_out  out  DATA_BITS  received word; stable while `o_data_ready` is high.
- o_data_ready  out  1  word valid; held until acknowledged.
- o_frame_err  out  1  qualifies the current word: the stop bit was sampled low.
- o_parity_err  out  1  qualifies the current word: parity mismatch. Constant 0 without the macro.
- o_overrun  out  1  one-cycle pulse: a completed frame was dropped.
- o_busy  out  1  high in every state except IDLE.

## Operation
- The RX pin passes through a 2-flop synchroniser with reset value 1. All logic below uses the synchronised signal.
- FSM states:
  - IDLE: on synchronised low, load bit counter with CLKS_PER_BIT/2 (integer) and go to START.
  - START: when the counter expires, sample. Low → DATA. High → glitch: return to IDLE, no flags.
  - DATA: reload the counter with CLKS_PER_BIT per bit and sample at each expiry. Shift into position DATA_BITS-1-k when MSB_FIRST=1, position k otherwise. After DATA_BITS samples → PARITY if the macro is enabled, else STOP.
  - PARITY: sample one bit and compare with the XOR of the data bits, XOR PARITY_ODD.
  - STOP: sample one bit. High → IDLE, or GUARD when STOP_BITS=2. Low → frame error, then go to BREAK.
  - GUARD: wait one bit period without checking, then IDLE.
  - BREAK: wait for the synchronised line to be high, then IDLE. No new start is accepted while in BREAK.
- Completion happens at the stop sample:
  - If `o_data_ready` is 0, or `i_data_ack` is 1 in the same cycle, load the word and both error flags into the holding register and set `o_data_ready`.
  - Otherwise drop the new word and error flags, leave the held word untouched, and pulse `o_overrun`.
- A frame with a frame error is still delivered, with `o_frame_err` set.
- When `i_data_ack` is high and `o_data_ready` is high with no completion, clear `o_data_ready`, `o_frame_err` and `o_parity_err` on the next cycle.
- `i_data_ack` while `o_data_ready` is low has no effect.
- Reset values: `o_data_byte_out` = 0; `o_data_ready`, `o_frame_err`, `o_parity_err`, `o_overrun`, `o_busy` = 0; FSM in IDLE; synchroniser = 1.
- Reset mid-frame abandons the frame; it is never delivered.

## Timing
- Edge at the pin in cycle E. D = E+2 is the first cycle IDLE sees the line low.
- Start sample at D + CLKS_PER_BIT/2.
- Data bit k is sampled at D + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Let P = 1 if parity is enabled, else 0. Stop sample at S = D + CLKS_PER_BIT/2 + (DATA_BITS+P+1)·CLKS_PER_BIT.
- `o_data_ready`, the word and the error flags are registered and visible in cycle S+1. `o_overrun` is high in cycle S+1 only.
- With STOP_BITS=1, a new start edge can be detected in cycle S+1. Back-to-back frames lose no bits.
- The ack handshake has zero-cycle acceptance and a one-cycle clear.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, frames carry one parity bit, and `o_parity_err` is live.
- Not defined: no parity bit is expected, the PARITY state and parity XOR logic are absent, and `o_parity_err` is tied to 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, GUARD, BREAK.
  - Counter width function clog2(CLKS_PER_BIT+1).
  - Synchroniser depth constant, set to 2.
- Sub-module `uart_rx_sync`: a 2-flop synchroniser with reset value 1. It is reused by the future TX loopback path.

## Test plan
- CLKS_PER_BIT=10, MSB_FIRST=1: send 0x79 at 10 clocks/bit with a high stop bit.
  - Expect `o_data_byte_out`=0x79 and `o_data_ready`=1 at S+1, with no error flags.
  - Ack, then expect `o_data_ready`=0 the next cycle.
- Glitch: drive the line low for 3 cycles, then high.
  - Expect `o_busy` to return to 0 and `o_data_ready` to stay 0.
- Framing error: send 0xA5 with the stop bit low, held low 3 bit periods.
  - Expect `o_data_byte_out`=0xA5 with `o_frame_err`=1.
  - No new frame is detected until the line returns high.
- Overrun: send 0x11 then 0x22 back-to-back with no ack.
  - Expect 0x11 to be held and `o_overrun` high for exactly one cycle at the second S+1.
  - Repeat with ack asserted at the second S; expect 0x22 loaded and no overrun.
- LSB first with parity: MSB_FIRST=0, DATA_BITS=7, `UART_RX_PARITY_EN` defined, PARITY_ODD=0, send 0x5A.
  - Correct parity → 0x5A with `o_parity_err`=0.
  - Flipped parity bit → 0x5A with `o_parity_err`=1.
- Reset mid-frame: assert `i_rst` for 1 cycle during data bit 3, then send 0x3C.
  - Expect all outputs 0 the cycle after reset.
  - The only word delivered is 0x3C.
